// File: rtl/fabric_config_loader.sv
// Bit-serial configuration loader: assembles a framed stream (header, payload, XOR checksum)
// into a shadow store and commits it to the flat configuration bus only when the checksum verifies.
module fabric_config_loader #(
  parameter int          NUM_WORDS = 23,
  parameter logic [15:0] MAGIC     = 16'hC0F6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cfg_en,
  input  logic                   cfg_bit,
  output logic [NUM_WORDS*32-1:0] config_bus,
  output logic                   cfg_done,
  output logic                   cfg_error,
  output logic                   busy
);

  localparam int BW = NUM_WORDS * 32;

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_PAYLOAD, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t          state_q;
  logic [31:0]     shift_q;
  logic [4:0]      cnt_q;
  logic [7:0]      idx_q;
  logic [31:0]     csum_q;
  logic [BW-1:0]   shadow_q;
  logic [BW-1:0]   config_q;
  logic            done_q;
  logic            error_q;
  logic            busy_q;

  logic [31:0]     word_d;
  logic            word_done;
  logic            header_ok;

  // word_d is the word as it will look once the current bit is shifted in.
  assign word_d    = {shift_q[30:0], cfg_bit};
  assign word_done = cfg_en && (cnt_q == 5'd31);
  assign header_ok = (word_d[31:16] == MAGIC) && (word_d[7:0] == 8'(NUM_WORDS));

  assign config_bus = config_q;
  assign cfg_done   = done_q;
  assign cfg_error  = error_q;
  assign busy       = busy_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      csum_q   <= '0;
      shadow_q <= '0;
      config_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (cfg_en && state_q != S_ERROR) begin
        shift_q <= word_d;
        cnt_q   <= cnt_q + 5'd1;
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (cfg_en) begin
            state_q <= S_HEADER;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            csum_q  <= '0;
          end
        end
        S_HEADER: begin
          if (word_done) begin
            if (header_ok) begin
              state_q <= S_PAYLOAD;
              idx_q   <= '0;
            end else begin
              state_q <= S_ERROR;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end
          end
        end
        S_PAYLOAD: begin
          if (word_done) begin
            shadow_q[{idx_q, 5'd0} +: 32] <= word_d;
            csum_q <= csum_q ^ word_d;
            idx_q  <= idx_q + 8'd1;
            if (idx_q == 8'(NUM_WORDS - 1)) state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (word_done) begin
            busy_q <= 1'b0;
            if (word_d == csum_q) begin
              state_q  <= S_DONE;
              config_q <= shadow_q;
              done_q   <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        default: ;  // S_ERROR is left only through reset
      endcase
    end
  end

endmodule

// File: tb/tb_fabric_config_loader.sv
// Bench for fabric_config_loader: directed frame scenarios with random payloads/gaps,
// every cycle checked against a frame-level reference model.
module tb_fabric_config_loader;

  localparam int          N          = 23;
  localparam logic [15:0] MAGIC      = 16'hC0F6;
  localparam int          BW         = N * 32;
  localparam int          FRAME_BITS = (N + 2) * 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_en = 1'b0;
  logic          cfg_bit = 1'b0;
  logic [BW-1:0] config_bus;
  logic          cfg_done;
  logic          cfg_error;
  logic          busy;

  fabric_config_loader #(.NUM_WORDS(N), .MAGIC(MAGIC)) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_en     (cfg_en),
    .cfg_bit    (cfg_bit),
    .config_bus (config_bus),
    .cfg_done   (cfg_done),
    .cfg_error  (cfg_error),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: tracks enabled bits of the current frame and judges whole words.
  logic [BW-1:0] m_bus = '0;
  logic          m_done = 1'b0;
  logic          m_err = 1'b0;
  logic          m_busy = 1'b0;
  int            m_bits = 0;
  logic [31:0]   m_cur = '0;
  logic [31:0]   m_words[$];

  int            cyc = 0;
  int            done_at = 0;
  int            frame_start = 0;
  logic          prev_done = 1'b0;
  logic [31:0]   frame_q[$];

  function automatic void model_edge(input logic rst, input logic en, input logic b);
    logic [31:0] acc;
    if (rst) begin
      m_bus = '0; m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0;
      m_bits = 0; m_words.delete();
    end else if (en && !m_err) begin
      m_cur  = {m_cur[30:0], b};
      m_bits = m_bits + 1;
      m_busy = 1'b1;
      m_done = 1'b0;
      if (m_bits % 32 == 0) begin
        m_words.push_back(m_cur);
        if (m_bits == 32 && !(m_cur[31:16] == MAGIC && m_cur[7:0] == 8'(N))) begin
          m_err = 1'b1; m_busy = 1'b0;
        end else if (m_bits == FRAME_BITS) begin
          acc = '0;
          for (int k = 1; k <= N; k++) acc = acc ^ m_words[k];
          if (acc == m_words[N+1]) begin
            for (int k = 0; k < N; k++) m_bus[k*32 +: 32] = m_words[k+1];
            m_done = 1'b1;
          end else begin
            m_err = 1'b1;
          end
          m_busy = 1'b0; m_bits = 0; m_words.delete();
        end
      end
    end
  endfunction

  task automatic check(input string tag);
    logic [BW+2:0] obs, exp;
    obs = {config_bus, cfg_done, cfg_error, busy};
    exp = {m_bus, m_done, m_err, m_busy};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed bus=%h done/err/busy=%b expected bus=%h done/err/busy=%b",
             tag, cyc, config_bus, {cfg_done, cfg_error, busy}, m_bus, {m_done, m_err, m_busy});
    end
  endtask

  task automatic check_val(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic b, input string tag);
    reset = rst; cfg_en = en; cfg_bit = b;
    @(posedge clock);
    cyc++;
    model_edge(rst, en, b);
    #1;
    check(tag);
    if (cfg_done && !prev_done) done_at = cyc;
    prev_done = cfg_done;
    reset = 1'b0; cfg_en = 1'b0; cfg_bit = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [31:0] good_hdr();
    return {MAGIC, 8'($urandom_range(0, 255)), 8'(N)};
  endfunction

  // directed=1 uses w0=0000_A5A5, wk=k*0x01010101; otherwise random payload.
  task automatic make_frame(input logic [31:0] hdr, input logic directed, input logic [31:0] flip);
    logic [31:0] w, acc;
    frame_q.delete();
    frame_q.push_back(hdr);
    acc = '0;
    for (int k = 0; k < N; k++) begin
      if (directed) w = (k == 0) ? 32'h0000_A5A5 : 32'(k) * 32'h0101_0101;
      else          w = $urandom();
      frame_q.push_back(w);
      acc = acc ^ w;
    end
    frame_q.push_back(acc ^ flip);
  endtask

  // Sends the first nbits of frame_q; gap idle cycles follow every 7th enabled bit.
  task automatic send(input int gap, input int nbits, input string tag);
    int bitn;
    logic [31:0] w;
    bitn = 0;
    done_at = 0;
    frame_start = cyc + 1;
    foreach (frame_q[i]) begin
      w = frame_q[i];
      for (int b = 31; b >= 0; b--) begin
        if (bitn < nbits) begin
          step(1'b0, 1'b1, w[b], tag);
          bitn++;
          if (gap > 0 && bitn % 7 == 0)
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), tag);
        end
      end
    end
  endtask

  task automatic check_latency(input string tag, input int expected);
    int lat;
    lat = (done_at == 0) ? 0 : done_at - frame_start + 1;
    check_val(tag, lat, expected);
  endtask

  initial begin
    int gap;
    logic [31:0] hdr;

    step(1'b1, 1'b0, 1'b0, "reset");
    step(1'b1, 1'b0, 1'b0, "reset");
    step(1'b0, 1'b0, 1'b0, "idle");

    // Directed gapless frame.
    make_frame(good_hdr(), 1'b1, 32'h0);
    send(0, FRAME_BITS, "frame_gapless");
    check_latency("lat_gapless", 800);
    check_val("w0", int'(config_bus[31:0]), 32'h0000_A5A5);
    check_val("w22", int'(config_bus[22*32 +: 32]), 32'h1616_1616);

    // Second frame with checksum off by one bit: error, bus keeps frame 1.
    make_frame(good_hdr(), 1'b0, 32'h1 << $urandom_range(0, 31));
    send(0, FRAME_BITS, "frame_badsum");
    check_val("badsum_err", int'({cfg_error, cfg_done}), 2);
    check_val("badsum_bus", int'(config_bus[31:0]), 32'h0000_A5A5);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), "err_traffic");

    // Bad magic header then ignored traffic.
    step(1'b1, 1'b0, 1'b0, "reset");
    make_frame(32'hC0F7_0017, 1'b0, 32'h0);
    send(0, 32 + 60, "bad_magic");
    check_val("bad_magic_bus0", int'(config_bus == '0), 1);

    // Bad word count field; reset together with cfg_en drops the bit.
    step(1'b1, 1'b1, 1'b1, "reset_with_en");
    step(1'b0, 1'b0, 1'b0, "idle");
    make_frame({MAGIC, 8'h00, 8'(N + 1)}, 1'b0, 32'h0);
    send(0, 40, "bad_len");
    step(1'b1, 1'b0, 1'b0, "reset");

    // Random single-bit corruption of the magic.
    hdr = good_hdr() ^ (32'h1 << $urandom_range(16, 31));
    make_frame(hdr, 1'b0, 32'h0);
    send(0, 48, "bad_magic_rand");
    step(1'b1, 1'b0, 1'b0, "reset");

    // Directed frame with 3-cycle gaps after every 7th bit.
    make_frame(good_hdr(), 1'b1, 32'h0);
    send(3, FRAME_BITS, "frame_gapped");
    check_latency("lat_gapped", 800 + 3 * (799 / 7));

    // Reset after 400 bits, then a full frame.
    make_frame(good_hdr(), 1'b0, 32'h0);
    send(0, 400, "partial");
    step(1'b1, 1'b1, 1'b1, "reset_mid");
    check_val("reset_mid_bus0", int'(config_bus == '0), 1);
    make_frame(good_hdr(), 1'b0, 32'h0);
    send(0, FRAME_BITS, "after_reset");
    check_latency("lat_after_reset", 800);

    // Two consecutive valid frames with random payloads and random gap lengths.
    for (int f = 0; f < 2; f++) begin
      gap = $urandom_range(0, 4);
      make_frame(good_hdr(), 1'b0, 32'h0);
      send(gap, FRAME_BITS, "consecutive");
      check_latency("lat_consecutive", 800 + gap * (799 / 7));
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), "tail");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
